// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the two-port memory read arbiter.
//   - arb_state_e   : arbiter FSM encoding (one-hot, 3 bits)
//   - PORT_I/PORT_D : requester ids (0 = I-cache, 1 = D-cache / uncached path)
//   - MAX_BEATS_DEF : default beats per burst (256-bit line over a 32-bit bus)
//   - cnt_width()   : beat counter width for a given burst length
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StReq  = 3'b010,
        StRsp  = 3'b100
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned MAX_BEATS_DEF = 8;

    // A burst of one beat still needs a 1-bit counter to keep widths legal.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mem_rd_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Purely combinational two-requester arbiter. The history bit (last_grant)
//   lives in the parent so the parent decides when a grant is "used".
//
//   Ports:
//     req        [1:0] request bits, bit N = port N
//     last_grant       port that completed the most recent burst
//     winner           selected port id (PORT_I when nobody requests)
//
//   Parameter RR_EN: 1 = alternate on contention, 0 = port 0 always wins.
// -----------------------------------------------------------------------------
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

    always_comb begin
        winner = PORT_I;
        case (req)
            2'b01:   winner = PORT_I;
            2'b10:   winner = PORT_D;
            // Contention: favour the port that did not go last.
            2'b11:   winner = RR_EN ? ~last_grant : PORT_I;
            default: winner = PORT_I;
        endcase
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rd_arbiter
//   Shares one burst read channel between two cache requesters. One burst is
//   in flight at a time; the grant is held from request until the last beat.
//   Response beats are steered to the owner only, and malformed bursts (wrong
//   length) raise a sticky error flag.
//
//   Ports (N = 0: I-cache, N = 1: D-cache / uncached):
//     clk, rst                 clock, async active-low reset
//     sN_rd_req_valid/addr     requester N read request (32-byte aligned)
//     sN_rd_req_ready          request N accepted by memory
//     sN_rd_rsp_valid/data/last  beat to requester N
//     sN_rd_rsp_ready          requester N accepts beat
//     m_rd_req_valid/addr/ready  request to memory (latched address)
//     m_rd_rsp_valid/data/last   beat from memory
//     m_rd_rsp_ready           beat accepted (owner ready, or idle drain)
//     grant_id                 current owner (meaningful outside idle)
//     burst_err                sticky malformed-burst flag
//
//   FSM: StIdle -> StReq -> StRsp -> StIdle. Idle always drains stray beats
//   from memory without forwarding them; at least one idle cycle separates
//   consecutive bursts.
// -----------------------------------------------------------------------------
module mem_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BEATS  = MAX_BEATS_DEF,
    parameter bit          RR_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    // Port 0
    input  logic                  s0_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] s0_rd_req_addr,
    output logic                  s0_rd_req_ready,
    output logic                  s0_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] s0_rd_rsp_data,
    output logic                  s0_rd_rsp_last,
    input  logic                  s0_rd_rsp_ready,

    // Port 1
    input  logic                  s1_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] s1_rd_req_addr,
    output logic                  s1_rd_req_ready,
    output logic                  s1_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] s1_rd_rsp_data,
    output logic                  s1_rd_rsp_last,
    input  logic                  s1_rd_rsp_ready,

    // Memory side
    output logic                  m_rd_req_valid,
    output logic [ADDR_WIDTH-1:0] m_rd_req_addr,
    input  logic                  m_rd_req_ready,
    input  logic                  m_rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] m_rd_rsp_data,
    input  logic                  m_rd_rsp_last,
    output logic                  m_rd_rsp_ready,

    // Status
    output logic                  grant_id,
    output logic                  burst_err
);

    localparam int unsigned     CntW    = cnt_width(MAX_BEATS);
    localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BEATS - 1);

    arb_state_e            state_q;
    logic                  grant_q;
    logic                  last_grant_q;
    logic                  err_q;
    logic [CntW-1:0]       beat_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic winner;
    logic any_req;
    logic own_rsp_ready;
    logic fwd_valid;
    logic rsp_hs;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_rr_arb2 (
        .req        ({s1_rd_req_valid, s0_rd_req_valid}),
        .last_grant (last_grant_q),
        .winner     (winner)
    );

    assign any_req = s0_rd_req_valid | s1_rd_req_valid;

    // -------------------------------------------------------------------------
    // Output steering (decoded from registered state / grant)
    // -------------------------------------------------------------------------
    assign grant_id      = grant_q;
    assign burst_err     = err_q;
    assign m_rd_req_addr = addr_q;

    assign own_rsp_ready = (grant_q == PORT_D) ? s1_rd_rsp_ready : s0_rd_rsp_ready;
    assign fwd_valid     = (state_q == StRsp) && m_rd_rsp_valid;
    assign rsp_hs        = fwd_valid && own_rsp_ready;

    always_comb begin
        m_rd_req_valid  = (state_q == StReq);
        s0_rd_req_ready = m_rd_req_valid && (grant_q == PORT_I) && m_rd_req_ready;
        s1_rd_req_ready = m_rd_req_valid && (grant_q == PORT_D) && m_rd_req_ready;

        // Idle accepts and drops anything memory sends; the request phase
        // refuses early beats so they wait for the response phase.
        m_rd_rsp_ready = 1'b1;
        unique case (state_q)
            StIdle:  m_rd_rsp_ready = 1'b1;
            StReq:   m_rd_rsp_ready = 1'b0;
            StRsp:   m_rd_rsp_ready = own_rsp_ready;
            default: m_rd_rsp_ready = 1'b1;
        endcase

        s0_rd_rsp_valid = fwd_valid && (grant_q == PORT_I);
        s1_rd_rsp_valid = fwd_valid && (grant_q == PORT_D);

        // Data/last are zeroed whenever the port's valid is low.
        s0_rd_rsp_data  = s0_rd_rsp_valid ? m_rd_rsp_data : '0;
        s0_rd_rsp_last  = s0_rd_rsp_valid && m_rd_rsp_last;
        s1_rd_rsp_data  = s1_rd_rsp_valid ? m_rd_rsp_data : '0;
        s1_rd_rsp_last  = s1_rd_rsp_valid && m_rd_rsp_last;
    end

    // -------------------------------------------------------------------------
    // FSM and burst bookkeeping
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            grant_q      <= PORT_I;
            last_grant_q <= PORT_D;
            err_q        <= 1'b0;
            beat_cnt_q   <= '0;
            addr_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_q <= winner;
                        addr_q  <= (winner == PORT_D) ? s1_rd_req_addr : s0_rd_req_addr;
                        state_q <= StReq;
                    end
                end

                // A requester withdrawing valid here has no effect: the
                // latched request is completed regardless.
                StReq: begin
                    if (m_rd_req_ready) begin
                        beat_cnt_q <= '0;
                        state_q    <= StRsp;
                    end
                end

                StRsp: begin
                    if (rsp_hs) begin
                        if (m_rd_rsp_last) begin
                            // Short burst: last arrived before the final slot.
                            if (beat_cnt_q != LastCnt) begin
                                err_q <= 1'b1;
                            end
                            last_grant_q <= grant_q;
                            state_q      <= StIdle;
                        end else if (beat_cnt_q == LastCnt) begin
                            // Overrun: keep forwarding until last shows up.
                            err_q <= 1'b1;
                        end
                        if (beat_cnt_q != LastCnt) begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Two arbiters side by side: index 0 is round-robin, index 1 is fixed priority.
// Stimulus pushes expected grants and beats into queues; a negedge monitor
// pops and compares whenever the DUT presents a handshake.
module tb_mem_rd_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic        port;
        logic [31:0] addr;
    } gnt_t;

    logic        clk;
    logic        rst [2];

    logic        s_req_valid [2][2];
    logic [31:0] s_req_addr  [2][2];
    logic        s_req_ready [2][2];
    logic        s_rsp_valid [2][2];
    logic [31:0] s_rsp_data  [2][2];
    logic        s_rsp_last  [2][2];
    logic        s_rsp_ready [2][2];

    logic        m_req_valid [2];
    logic [31:0] m_req_addr  [2];
    logic        m_req_ready [2];
    logic        m_rsp_valid [2];
    logic [31:0] m_rsp_data  [2];
    logic        m_rsp_last  [2];
    logic        m_rsp_ready [2];
    logic        grant       [2];
    logic        err         [2];

    beat_t exp_q [2][2][$];
    gnt_t  gnt_q [2][$];

    int total = 0;
    int bad   = 0;
    bit tog_en;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_rd_arbiter #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MAX_BEATS  (8),
            .RR_EN      (g == 0)
        ) u_dut (
            .clk             (clk),
            .rst             (rst[g]),
            .s0_rd_req_valid (s_req_valid[g][0]),
            .s0_rd_req_addr  (s_req_addr[g][0]),
            .s0_rd_req_ready (s_req_ready[g][0]),
            .s0_rd_rsp_valid (s_rsp_valid[g][0]),
            .s0_rd_rsp_data  (s_rsp_data[g][0]),
            .s0_rd_rsp_last  (s_rsp_last[g][0]),
            .s0_rd_rsp_ready (s_rsp_ready[g][0]),
            .s1_rd_req_valid (s_req_valid[g][1]),
            .s1_rd_req_addr  (s_req_addr[g][1]),
            .s1_rd_req_ready (s_req_ready[g][1]),
            .s1_rd_rsp_valid (s_rsp_valid[g][1]),
            .s1_rd_rsp_data  (s_rsp_data[g][1]),
            .s1_rd_rsp_last  (s_rsp_last[g][1]),
            .s1_rd_rsp_ready (s_rsp_ready[g][1]),
            .m_rd_req_valid  (m_req_valid[g]),
            .m_rd_req_addr   (m_req_addr[g]),
            .m_rd_req_ready  (m_req_ready[g]),
            .m_rd_rsp_valid  (m_rsp_valid[g]),
            .m_rd_rsp_data   (m_rsp_data[g]),
            .m_rd_rsp_last   (m_rsp_last[g]),
            .m_rd_rsp_ready  (m_rsp_ready[g]),
            .grant_id        (grant[g]),
            .burst_err       (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (s_rsp_valid[d][p] && s_rsp_ready[d][p]) begin
                    if (exp_q[d][p].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat dut%0d port%0d: got data %0h, want none",
                                 d, p, s_rsp_data[d][p]);
                    end else begin
                        beat_t e;
                        e = exp_q[d][p].pop_front();
                        check($sformatf("beat_data dut%0d p%0d", d, p), s_rsp_data[d][p], e.data);
                        check($sformatf("beat_last dut%0d p%0d", d, p), s_rsp_last[d][p], e.last);
                    end
                end else if (!s_rsp_valid[d][p]) begin
                    check($sformatf("idle_zero dut%0d p%0d", d, p),
                          {s_rsp_last[d][p], s_rsp_data[d][p]}, '0);
                end
            end
            if (m_req_valid[d] && m_req_ready[d]) begin
                if (gnt_q[d].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant dut%0d: got port %0d, want none", d, grant[d]);
                end else begin
                    gnt_t g;
                    g = gnt_q[d].pop_front();
                    check($sformatf("grant_id dut%0d", d), grant[d], g.port);
                    check($sformatf("req_addr dut%0d", d), m_req_addr[d], g.addr);
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b0;
        @(negedge clk);
        rst[d] = 1'b1;
        tick();
    endtask

    task automatic req_issue(input int d, input int p, input logic [31:0] a);
        gnt_t g;
        s_req_valid[d][p] = 1'b1;
        s_req_addr[d][p]  = a;
        g.port = p[0];
        g.addr = a;
        gnt_q[d].push_back(g);
    endtask

    task automatic expect_grant(input int d, input int p, input logic [31:0] a);
        gnt_t g;
        g.port = p[0];
        g.addr = a;
        gnt_q[d].push_back(g);
    endtask

    task automatic req_wait(input int d, input int p, input bit keep);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_req_ready[d][p]) done = 1'b1;
            tick();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL req_timeout dut%0d port%0d: got no ready, want ready", d, p);
        end
        if (!keep) s_req_valid[d][p] = 1'b0;
    endtask

    task automatic send_beat(input int d, input logic [31:0] data, input bit last,
                             input int mp, input bit chk_cnt);
        bit done = 1'b0;
        m_rsp_valid[d] = 1'b1;
        m_rsp_data[d]  = data;
        m_rsp_last[d]  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (mp >= 0) check("rsp_ready_mirror", m_rsp_ready[d], s_rsp_ready[d][mp]);
            if (m_rsp_ready[d]) begin
                done = 1'b1;
                if (chk_cnt) check("beat_cnt_at_last", g_dut[0].u_dut.beat_cnt_q, 7);
            end
            tick();
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL beat_timeout dut%0d: got no m_rd_rsp_ready, want ready", d);
        end
        m_rsp_valid[d] = 1'b0;
        m_rsp_data[d]  = '0;
        m_rsp_last[d]  = 1'b0;
    endtask

    task automatic serve(input int d, input int p, input logic [31:0] base, input int n,
                         input int last_at, input int mp, input bit chk_cnt);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = base + i;
            b.last = (i == last_at - 1);
            exp_q[d][p].push_back(b);
        end
        for (int i = 0; i < n; i++) begin
            send_beat(d, base + i, (i == last_at - 1), mp, chk_cnt && (i == n - 1));
        end
        tick();
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]         = 1'b1;
            m_req_ready[d] = 1'b1;
            m_rsp_valid[d] = 1'b0;
            m_rsp_data[d]  = '0;
            m_rsp_last[d]  = 1'b0;
            for (int p = 0; p < 2; p++) begin
                s_req_valid[d][p] = 1'b0;
                s_req_addr[d][p]  = '0;
                s_rsp_ready[d][p] = 1'b1;
            end
        end
        #2;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();
        tick();

        // Reset values
        for (int d = 0; d < 2; d++) begin
            check("rst_grant", grant[d], 0);
            check("rst_err", err[d], 0);
            check("rst_m_req_valid", m_req_valid[d], 0);
            check("rst_m_req_addr", m_req_addr[d], 0);
            check("rst_m_rsp_ready", m_rsp_ready[d], 1);
            check("rst_s0_req_ready", s_req_ready[d][0], 0);
            check("rst_s1_req_ready", s_req_ready[d][1], 0);
        end
        @(negedge clk);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        tick();

        // Single request on port 0, one-cycle request latency
        req_issue(0, 0, 32'h0000_1020);
        check("lat_pre_valid", m_req_valid[0], 0);
        tick();
        check("lat_valid", m_req_valid[0], 1);
        check("lat_addr", m_req_addr[0], 32'h0000_1020);
        req_wait(0, 0, 1'b0);
        serve(0, 0, 32'hA0, 8, 8, -1, 1'b0);
        check("single_err", err[0], 0);

        // Round-robin from reset: 0,1,0,1 with both ports continuously requesting
        do_reset(0);
        s_req_valid[0][0] = 1'b1;
        s_req_addr[0][0]  = 32'h0000_2000;
        s_req_valid[0][1] = 1'b1;
        s_req_addr[0][1]  = 32'h0000_3000;
        for (int k = 0; k < 4; k++) begin
            int p;
            p = k % 2;
            expect_grant(0, p, (p == 0) ? 32'h0000_2000 : 32'h0000_3000);
            req_wait(0, p, k < 2);
            serve(0, p, 32'hB000 + k * 16, 8, 8, -1, 1'b0);
        end
        check("rr_err", err[0], 0);

        // Backpressure on port 1: owner ready toggles every cycle
        req_issue(0, 1, 32'h0000_4040);
        req_wait(0, 1, 1'b0);
        tog_en = 1'b1;
        fork
            begin
                serve(0, 1, 32'hC0, 8, 8, 1, 1'b1);
                tog_en = 1'b0;
            end
            begin
                while (tog_en) begin
                    @(posedge clk);
                    #1;
                    if (tog_en) s_rsp_ready[0][1] = !s_rsp_ready[0][1];
                end
            end
        join
        s_rsp_ready[0][1] = 1'b1;
        check("bp_err", err[0], 0);

        // Short burst: last on the 6th beat
        req_issue(0, 0, 32'h0000_5000);
        req_wait(0, 0, 1'b0);
        serve(0, 0, 32'hD0, 6, 6, -1, 1'b0);
        check("short_err", err[0], 1);
        check("short_idle_rsp_ready", m_rsp_ready[0], 1);
        check("short_idle_req_valid", m_req_valid[0], 0);

        // Overrun: 9 beats, last on the 9th, all forwarded
        do_reset(0);
        check("reset_clears_err", err[0], 0);
        req_issue(0, 1, 32'h0000_6020);
        req_wait(0, 1, 1'b0);
        serve(0, 1, 32'hE0, 9, 9, -1, 1'b0);
        check("overrun_err", err[0], 1);

        // Asynchronous reset in the middle of a port-1 burst
        do_reset(0);
        req_issue(0, 1, 32'h0000_7000);
        req_wait(0, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            beat_t b;
            b.data = 32'hF0 + i;
            b.last = 1'b0;
            exp_q[0][1].push_back(b);
        end
        for (int i = 0; i < 3; i++) send_beat(0, 32'hF0 + i, 1'b0, -1, 1'b0);
        m_rsp_valid[0] = 1'b1;
        m_rsp_data[0]  = 32'hF3;
        m_rsp_last[0]  = 1'b0;
        #1;
        check("pre_arst_fwd", s_rsp_valid[0][1], 1);
        check("pre_arst_grant", grant[0], 1);
        rst[0] = 1'b0;
        #1;
        check("arst_fwd_clear", s_rsp_valid[0][1], 0);
        check("arst_data_clear", s_rsp_data[0][1], 0);
        check("arst_grant", grant[0], 0);
        check("arst_rsp_ready", m_rsp_ready[0], 1);
        check("arst_req_valid", m_req_valid[0], 0);
        @(negedge clk);
        rst[0] = 1'b1;
        for (int i = 3; i < 8; i++) send_beat(0, 32'hF0 + i, (i == 7), -1, 1'b0);
        tick();
        check("drain_req_valid", m_req_valid[0], 0);
        req_issue(0, 0, 32'h0000_1040);
        req_wait(0, 0, 1'b0);
        serve(0, 0, 32'h50, 8, 8, -1, 1'b0);
        check("post_arst_err", err[0], 0);

        // Fixed priority: port 0 keeps requesting, port 1 waits until it stops
        s_req_valid[1][0] = 1'b1;
        s_req_addr[1][0]  = 32'h0000_8000;
        s_req_valid[1][1] = 1'b1;
        s_req_addr[1][1]  = 32'h0000_9000;
        for (int k = 0; k < 4; k++) begin
            int p;
            p = (k < 3) ? 0 : 1;
            expect_grant(1, p, (p == 0) ? 32'h0000_8000 : 32'h0000_9000);
            req_wait(1, p, k < 2);
            serve(1, p, 32'h300 + k * 16, 8, 8, -1, 1'b0);
        end
        check("fp_err", err[1], 0);

        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check("gnt_q_empty", gnt_q[d].size(), 0);
            for (int p = 0; p < 2; p++) check("exp_q_empty", exp_q[d][p].size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want $finish");
        $fatal(1, "watchdog");
    end

endmodule
